// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Branch immediate field layout and PC arithmetic constants live here.
package fetch_stage_pkg;

    localparam int unsigned B_IMM_MSB  = 23;
    localparam int unsigned B_IMM_LSB  = 0;
    localparam int unsigned B_IMM_W    = B_IMM_MSB - B_IMM_LSB + 1;
    localparam logic [31:0] PC_AHEAD   = 32'd8;
    localparam logic [31:0] INST_BYTES = 32'd4;

    typedef enum logic [1:0] {
        FETCH_NORMAL,
        FETCH_STALL,
        FETCH_REDIRECT
    } fetch_mode_e;

    // Word offset of a B-type immediate, sign-extended to a byte offset.
    function automatic logic [31:0] b_offset(input logic [B_IMM_W-1:0] imm);
        return {{(32 - B_IMM_W - 2){imm[B_IMM_W-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, decode control and IF/ID outputs.
// master = fetch stage, slave = memory/decode environment.
interface fetch_stage_if;

    logic        stall;
    logic        branch_taken;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;

    modport master (
        input  stall, branch_taken, imem_rdata,
        output imem_en, imem_addr, inst, inst_pc, inst_valid
    );

    modport slave (
        output stall, branch_taken, imem_rdata,
        input  imem_en, imem_addr, inst, inst_pc, inst_valid
    );

endinterface

// File: rtl/fetch_stage_branch_target.sv
// Branch target adder: pc + 8 + sign-extended imm24 words, wrapping mod 2^32.
module fetch_stage_branch_target
    import fetch_stage_pkg::*;
(
    input  logic [31:0]        pc,
    input  logic [B_IMM_W-1:0] imm24,
    output logic [31:0]        target
);

    assign target = pc + PC_AHEAD + b_offset(imm24);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, synchronous imem read, IF/ID register,
// taken-branch redirect and a one-entry skid buffer for decode stalls.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_req_valid;
    logic [31:0] r_skid;
    logic [31:0] r_skid_pc;
    logic        r_skid_valid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_inst_valid;

    logic        w_redirect;
    logic [31:0] w_target;
    fetch_mode_e w_mode;

    fetch_stage_branch_target u_branch_target (
        .pc     (r_inst_pc),
        .imm24  (r_inst[B_IMM_MSB:B_IMM_LSB]),
        .target (w_target)
    );

    // Redirect outranks stall: a taken branch squashes whatever decode holds.
    always_comb begin
        w_redirect = bus.branch_taken & r_inst_valid;
        if (w_redirect) begin
            w_mode = FETCH_REDIRECT;
        end else if (bus.stall) begin
            w_mode = FETCH_STALL;
        end else begin
            w_mode = FETCH_NORMAL;
        end
    end

    always_comb begin
        bus.imem_en   = 1'b0;
        bus.imem_addr = r_pc;
        if (!reset) begin
            case (w_mode)
                FETCH_REDIRECT: begin
                    bus.imem_en   = 1'b1;
                    bus.imem_addr = w_target;
                end
                FETCH_NORMAL: bus.imem_en = 1'b1;
                default:      bus.imem_en = 1'b0;
            endcase
        end
    end

    assign bus.inst       = r_inst;
    assign bus.inst_pc    = r_inst_pc;
    assign bus.inst_valid = r_inst_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_req_pc     <= '0;
            r_req_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_pc    <= '0;
            r_skid_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
        end else begin
            case (w_mode)
                FETCH_REDIRECT: begin
                    r_pc         <= w_target + INST_BYTES;
                    r_req_pc     <= w_target;
                    r_req_valid  <= 1'b1;
                    r_inst_valid <= 1'b0;
                    r_skid_valid <= 1'b0;
                end
                FETCH_STALL: begin
                    // The read issued last cycle returns now; park it until decode frees up.
                    r_req_valid <= 1'b0;
                    if (r_req_valid) begin
                        r_skid       <= bus.imem_rdata;
                        r_skid_pc    <= r_req_pc;
                        r_skid_valid <= 1'b1;
                    end
                end
                default: begin
                    r_pc        <= r_pc + INST_BYTES;
                    r_req_pc    <= r_pc;
                    r_req_valid <= 1'b1;
                    if (r_skid_valid) begin
                        r_inst       <= r_skid;
                        r_inst_pc    <= r_skid_pc;
                        r_inst_valid <= 1'b1;
                        r_skid_valid <= 1'b0;
                    end else if (r_req_valid) begin
                        r_inst       <= bus.imem_rdata;
                        r_inst_pc    <= r_req_pc;
                        r_inst_valid <= 1'b1;
                    end else begin
                        r_inst_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that feeds `decode_inst`. It owns the program counter and drives a synchronous instruction memory with one-cycle read latency. It holds the IF/ID pipeline register (instruction, PC, valid) consumed by decode, and applies taken-branch redirects computed from the instruction currently in IF/ID. A one-entry skid register keeps an in-flight read from being lost when decode stalls.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; word-aligned.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `stall` in 1: decode cannot accept; hold IF/ID and PC.
- `branch_taken` in 1: decode resolved the IF/ID instruction as a taken branch (`branch_inst & cond_execute`); ignored when `inst_valid`=0.
- `imem_en` out 1: read strobe to instruction memory.
- `imem_addr` out 32: byte address of read, bits[1:0]=0.
- `imem_rdata` in 32: read data, valid the cycle after `imem_en`.
- `inst` out 32: IF/ID instruction to decode.
- `inst_pc` out 32: byte address of `inst`.
- `inst_valid` out 1: `inst` is a real instruction (0 = bubble).

## Operation
- State: `pc_q` (next fetch address), `req_pc_q`/`req_valid_q` (read outstanding, data on `imem_rdata` this cycle), `skid_q`/`skid_pc_q`/`skid_valid_q`, IF/ID regs `inst`/`inst_pc`/`inst_valid`.
- Branch target = `inst_pc` + 8 + (sign-extend `inst[23:0]`) << 2, modulo 2^32; overflow wraps silently.
- Redirect = `branch_taken & inst_valid`. Priority per cycle: reset > redirect > stall > normal.
- Redirect: `imem_en`=1, `imem_addr`=target (combinational); `pc_q`<=target+4; `req_pc_q`<=target, `req_valid_q`<=1; `inst_valid`<=0; `skid_valid_q`<=0; returning `imem_rdata` discarded. `stall` ignored this cycle.
- Stall (no redirect): `imem_en`=0; `pc_q`, IF/ID hold; `req_valid_q`<=0; if `req_valid_q`, `skid_q`<=`imem_rdata`, `skid_pc_q`<=`req_pc_q`, `skid_valid_q`<=1.
- Normal: `imem_en`=1, `imem_addr`=`pc_q`; `pc_q`<=`pc_q`+4; `req_pc_q`<=`pc_q`, `req_valid_q`<=1. IF/ID loads, in priority: skid (then `skid_valid_q`<=0), else `imem_rdata`/`req_pc_q` if `req_valid_q`, else bubble (`inst_valid`<=0).
- Invariant: `skid_valid_q` and `req_valid_q` are never both 1; a bench assertion checks this.
- `inst`/`inst_pc` hold their last value when `inst_valid`=0.

## Timing
- Reset values: `pc_q`=`RESET_PC`, `req_valid_q`=0, `skid_valid_q`=0, `inst`=0, `inst_pc`=0, `inst_valid`=0. `imem_en`=0 while `reset` is high.
- The first cycle after reset release issues `RESET_PC`. The first `inst_valid`=1 appears 2 cycles after release.
- Fetch-to-IF/ID latency: 2 cycles (address cycle N, data N+1, visible N+2). Steady-state throughput is 1 instruction per cycle.
- Taken branch in cycle N: bubble at N+1, target valid at N+2. Penalty is 1 cycle.
- Stall release: the skid entry appears the following cycle with no bubble and no duplicate. The next fetch issues in the release cycle.
- Reset asserted mid-stall or mid-redirect: all state is cleared at once and the outstanding read is discarded.

## Structure
- Add to `arm_constants.v`: `B_IMM_MSB`/`B_IMM_LSB` (23/0), `PC_AHEAD` (8), `INST_BYTES` (4).
- One natural combinational sub-module: `branch_target` (inputs pc, imm24; output 32-bit target). The skid and IF/ID logic stay inline.

## Test plan
- Reset, memory holds word = address: `imem_addr` 0,4,8… from cycle 1; `inst_valid` rises cycle 2 with `inst_pc`=0, then +4 per cycle.
- `stall` high 3 cycles while PC 0x10 is in flight: IF/ID holds 0x0C; after release, IF/ID shows 0x10 then 0x14. No gap, no duplicate, no skipped address.
- B at 0x20 with imm24=0x000004, `branch_taken`=1: one bubble, then `inst_pc`=0x38. The word fetched at 0x24 is never valid.
- Backward branch at 0x40 with imm24=0xFFFFFE: target 0x40. Repeated `branch_taken` loops at 0x40 with alternating bubble.
- `branch_taken` and `stall` in the same cycle, with a skid entry pending: redirect wins, skid is dropped, and the next valid `inst_pc` is the target.
- `reset` pulsed asynchronously mid-stream: outputs clear without a clock edge, and fetch restarts at `RESET_PC`.
